// File: rtl/y86_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The master modport is the arbiter's view. The slave modport is the environment's view.
interface y86_mem_arbiter_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    // fetch port
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_done;
    logic              f_err;

    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_err;

    // memory side and status
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              owner_d;
    logic              busy;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output f_rdata, f_done, f_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner_d, busy
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  f_rdata, f_done, f_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner_d, busy
    );
endinterface

// File: rtl/y86_mem_arbiter.sv
// Shares one single-ported variable-latency memory between the fetch (F) and data (D) ports.
// D has priority, with a bounded streak so that F cannot starve. Transactions run one at a time.
module y86_mem_arbiter #(
    parameter int unsigned MEM_BYTES  = 8192,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    y86_mem_arbiter_if.master bus
);
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned EXT_W    = ADDR_W + 1;
    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [EXT_W-1:0] MEM_END = EXT_W'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [STREAK_W-1:0] r_streak;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_owner_d;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_grant_d;
    logic w_grant_f;
    logic w_d_bad;
    logic w_f_bad;
    logic w_req_err;
    logic w_timeout;
    logic w_done;

    // Arbitration and request checks; the 65-bit compare keeps d_addr+8 from wrapping.
    always_comb begin
        w_grant_d = bus.d_req && (!bus.f_req || (r_streak < STREAK_W'(MAX_STREAK)));
        w_grant_f = !w_grant_d && bus.f_req;
        w_d_bad   = ({1'b0, bus.d_addr} >= MEM_END)
                 || (({1'b0, bus.d_addr} + EXT_W'(8)) > MEM_END)
                 || (bus.d_addr[2:0] != 3'd0);
        w_f_bad   = ({1'b0, bus.f_addr} >= MEM_END);
        w_req_err = w_grant_d ? w_d_bad : w_f_bad;
        w_timeout = (r_tmo == TMO_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant_d || w_grant_f) w_next_state = w_req_err ? S_DONE : S_WAIT;
            S_WAIT:  if (bus.mem_ack || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction latch, streak and timeout counters, and the result that the DONE cycle reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak  <= '0;
            r_tmo     <= '0;
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_d || w_grant_f) begin
                        r_owner_d <= w_grant_d;
                        r_addr    <= w_grant_d ? bus.d_addr : bus.f_addr;
                        r_we      <= w_grant_d && bus.d_we;
                        r_wdata   <= w_grant_d ? bus.d_wdata : '0;
                        r_err     <= w_req_err;
                        if (w_grant_d && bus.f_req) begin
                            r_streak <= (r_streak < STREAK_W'(MAX_STREAK)) ? r_streak + STREAK_W'(1) : r_streak;
                        end else begin
                            r_streak <= '0;
                        end
                        if (w_req_err) begin
                            if (w_grant_d) r_d_rdata <= '0;
                            else           r_f_rdata <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ack) begin
                        r_err <= 1'b0;
                        r_tmo <= '0;
                        if (r_owner_d) r_d_rdata <= r_we ? '0 : bus.mem_rdata;
                        else           r_f_rdata <= bus.mem_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_tmo <= '0;
                        if (r_owner_d) r_d_rdata <= '0;
                        else           r_f_rdata <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_DONE:  r_tmo <= '0;
                default: r_tmo <= '0;
            endcase
        end
    end

    always_comb begin
        w_done        = (r_state == S_DONE);
        bus.mem_req   = (r_state == S_WAIT);
        bus.mem_we    = (r_state == S_WAIT) && r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.f_done    = w_done && !r_owner_d;
        bus.d_done    = w_done && r_owner_d;
        bus.f_err     = w_done && !r_owner_d && r_err;
        bus.d_err     = w_done && r_owner_d && r_err;
        bus.f_rdata   = r_f_rdata;
        bus.d_rdata   = r_d_rdata;
        bus.owner_d   = r_owner_d;
        bus.busy      = (r_state != S_IDLE);
    end
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: a timeline model of each transaction is checked every cycle,
// and each directed case also checks hand-computed literal values.
module tb_y86_mem_arbiter;
    localparam int unsigned MEM_BYTES  = 8192;
    localparam int unsigned MAX_STREAK = 4;
    localparam int unsigned TIMEOUT    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    y86_mem_arbiter_if bus();

    y86_mem_arbiter #(
        .MEM_BYTES (MEM_BYTES),
        .MAX_STREAK(MAX_STREAK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    bit     chk_en = 1'b0;

    // memory responder configuration: ack on the ack_at-th mem_req cycle (0 = never)
    int          ack_at    = 1;
    logic [63:0] mem_data  = '0;
    bit          force_ack = 1'b0;
    int          req_cnt   = 0;

    int          f_done_cnt = 0;
    int          d_done_cnt = 0;
    int          mreq_cnt   = 0;
    int          wr_ok_cnt  = 0;
    logic [63:0] last_maddr = '0;
    logic        last_mwe   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: each grant fixes the start cycle, the done cycle and the result of the transaction.
    longint      m_start  = -10;
    longint      m_done   = -10;
    bit          m_own    = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_we     = 1'b0;
    logic [63:0] m_addr   = '0;
    logic [63:0] m_wdata  = '0;
    logic [63:0] m_res    = '0;
    logic [63:0] m_f_rd   = '0;
    logic [63:0] m_d_rd   = '0;
    int          m_streak = 0;

    initial begin
        bit gd;
        bit ok;
        bit bad_a;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_start  = -10;
                m_done   = cyc - 1;
                m_own    = 1'b0;
                m_err    = 1'b0;
                m_we     = 1'b0;
                m_addr   = '0;
                m_wdata  = '0;
                m_f_rd   = '0;
                m_d_rd   = '0;
                m_streak = 0;
            end else begin
                if (cyc >= m_done + 2) begin
                    gd = bus.d_req && (!bus.f_req || (m_streak < int'(MAX_STREAK)));
                    if (gd || bus.f_req) begin
                        m_own   = gd;
                        m_start = cyc;
                        m_addr  = gd ? bus.d_addr : bus.f_addr;
                        m_we    = gd && bus.d_we;
                        m_wdata = bus.d_wdata;
                        if (gd && bus.f_req) m_streak = (m_streak >= int'(MAX_STREAK)) ? int'(MAX_STREAK) : m_streak + 1;
                        else                 m_streak = 0;
                        if (gd) bad_a = (({1'b0, bus.d_addr} + 65'd8) > 65'(MEM_BYTES))
                                     || (bus.d_addr >= 64'(MEM_BYTES)) || ((bus.d_addr % 64'd8) != 64'd0);
                        else    bad_a = (bus.f_addr >= 64'(MEM_BYTES));
                        ok = (ack_at >= 1) && (ack_at <= int'(TIMEOUT));
                        if (bad_a) begin
                            m_err  = 1'b1;
                            m_done = cyc;
                            m_res  = '0;
                        end else begin
                            m_err  = !ok;
                            m_done = cyc + longint'(ok ? ack_at : int'(TIMEOUT));
                            m_res  = (ok && !m_we) ? mem_data : 64'd0;
                        end
                    end
                end
                if (cyc == m_done) begin
                    if (m_own) m_d_rd = m_res;
                    else       m_f_rd = m_res;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        bit e_busy;
        bit e_req;
        bit e_fd;
        bit e_dd;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_busy = (cyc >= m_start) && (cyc <= m_done);
                e_req  = e_busy && (cyc < m_done);
                e_fd   = (cyc == m_done) && !m_own;
                e_dd   = (cyc == m_done) && m_own;
                chk("busy",    64'(bus.busy),    64'(e_busy));
                chk("mem_req", 64'(bus.mem_req), 64'(e_req));
                chk("f_done",  64'(bus.f_done),  64'(e_fd));
                chk("d_done",  64'(bus.d_done),  64'(e_dd));
                chk("f_err",   64'(bus.f_err),   64'(e_fd && m_err));
                chk("d_err",   64'(bus.d_err),   64'(e_dd && m_err));
                chk("f_rdata", bus.f_rdata,      m_f_rd);
                chk("d_rdata", bus.d_rdata,      m_d_rd);
                chk("owner_d", 64'(bus.owner_d), 64'(m_own));
                if (e_req) begin
                    chk("mem_addr", bus.mem_addr,    m_addr);
                    chk("mem_we",   64'(bus.mem_we), 64'(m_we));
                    if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
                end
            end
        end
    end

    // Memory responder.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) req_cnt++;
            else                      req_cnt = 0;
            bus.mem_ack   = force_ack || ((bus.mem_req === 1'b1) && (req_cnt == ack_at));
            bus.mem_rdata = bus.mem_ack ? mem_data : 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // Event counters read by the directed cases.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (bus.f_done) f_done_cnt++;
            if (bus.d_done) d_done_cnt++;
            if (bus.mem_req) begin
                mreq_cnt++;
                last_maddr = bus.mem_addr;
                last_mwe   = bus.mem_we;
                if (bus.mem_we && (bus.mem_wdata == 64'hDEAD_BEEF)) wr_ok_cnt++;
            end
        end
    end

    // Raise one request, wait (bounded) for its done, then drop it in the cycle after done.
    task automatic do_req(input bit is_d, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat, output logic err, output logic [63:0] rdata, output int nreq);
        longint c0;
        int     n0;
        bit     seen;
        c0   = cyc;
        n0   = mreq_cnt;
        seen = 1'b0;
        lat  = 0;
        err  = 1'bx;
        rdata = 'x;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.f_req = 1'b1; bus.f_addr = addr;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (is_d ? bus.d_done : bus.f_done) begin
                seen  = 1'b1;
                lat   = int'(cyc - c0) + 1;
                err   = is_d ? bus.d_err : bus.f_err;
                rdata = is_d ? bus.d_rdata : bus.f_rdata;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_wait: no done within 40 cycles for addr %h", addr);
        end
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        nreq = mreq_cnt - n0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          nreq;
        logic        e;
        logic [63:0] rd;
        int          d0;
        int          f0;
        int          w0;
        int          k;
        string       order;

        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_f_rdata", bus.f_rdata,      64'd0);
        chk("rst_d_rdata", bus.d_rdata,      64'd0);
        chk("rst_owner",   64'(bus.owner_d), 64'd0);
        @(posedge clk); #1;

        // F read, ack on the 2nd mem_req cycle
        ack_at = 2; mem_data = 64'h1122_3344_5566_7788; d0 = d_done_cnt;
        do_req(1'b0, 1'b0, 64'h10, 64'd0, lat, e, rd, nreq);
        chk("t1_rdata", rd, 64'h1122_3344_5566_7788);
        chk("t1_err",   64'(e), 64'd0);
        chk("t1_nreq",  64'(nreq), 64'd2);
        chk("t1_lat",   64'(lat), 64'd4);
        chk("t1_maddr", last_maddr, 64'h10);
        chk("t1_mwe",   64'(last_mwe), 64'd0);
        chk("t1_ddone", 64'(d_done_cnt - d0), 64'd0);

        // Both ports requesting continuously: D wins MAX_STREAK times, then F
        ack_at = 1; mem_data = 64'h0123_4567_89AB_CDEF; order = "";
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h100;
        bus.f_req = 1'b1; bus.f_addr = 64'h200;
        for (int i = 0; i < 200 && order.len() < 10; i++) begin
            @(negedge clk);
            if (bus.d_done) order = {order, "D"};
            if (bus.f_done) order = {order, "F"};
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.f_req = 1'b0;
        total++;
        if (order != "DDDDFDDDDF") begin
            bad++;
            $display("FAIL t2_order: got %s expected DDDDFDDDDF", order);
        end

        // D write
        ack_at = 3; w0 = wr_ok_cnt;
        do_req(1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF, lat, e, rd, nreq);
        chk("t3_rdata", rd, 64'd0);
        chk("t3_err",   64'(e), 64'd0);
        chk("t3_nreq",  64'(nreq), 64'd3);
        chk("t3_wr",    64'(wr_ok_cnt - w0), 64'd3);
        chk("t3_lat",   64'(lat), 64'd5);

        // Address boundaries
        ack_at = 1; mem_data = 64'h0000_0000_0000_CAFE;
        do_req(1'b1, 1'b0, 64'd8184, 64'd0, lat, e, rd, nreq);
        chk("t4_last_err",   64'(e), 64'd0);
        chk("t4_last_rdata", rd, 64'hCAFE);
        chk("t4_last_lat",   64'(lat), 64'd3);
        do_req(1'b1, 1'b0, 64'h43, 64'd0, lat, e, rd, nreq);
        chk("t4_mis_err",   64'(e), 64'd1);
        chk("t4_mis_rdata", rd, 64'd0);
        chk("t4_mis_lat",   64'(lat), 64'd2);
        chk("t4_mis_nreq",  64'(nreq), 64'd0);
        do_req(1'b1, 1'b0, 64'd8192, 64'd0, lat, e, rd, nreq);
        chk("t4_oor_err",  64'(e), 64'd1);
        chk("t4_oor_lat",  64'(lat), 64'd2);
        chk("t4_oor_nreq", 64'(nreq), 64'd0);
        do_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, lat, e, rd, nreq);
        chk("t4_wrap_err", 64'(e), 64'd1);
        do_req(1'b0, 1'b0, 64'd8192, 64'd0, lat, e, rd, nreq);
        chk("t4_f_oor_err", 64'(e), 64'd1);
        chk("t4_f_oor_lat", 64'(lat), 64'd2);
        mem_data = 64'h7777_0000_1111_2222;
        do_req(1'b0, 1'b0, 64'd8191, 64'd0, lat, e, rd, nreq);
        chk("t4_f_odd_err",   64'(e), 64'd0);
        chk("t4_f_odd_rdata", rd, 64'h7777_0000_1111_2222);

        // Timeout handling
        ack_at = 0;
        do_req(1'b0, 1'b0, 64'h300, 64'd0, lat, e, rd, nreq);
        chk("t5_to_err",   64'(e), 64'd1);
        chk("t5_to_rdata", rd, 64'd0);
        chk("t5_to_nreq",  64'(nreq), 64'd16);
        chk("t5_to_lat",   64'(lat), 64'd18);
        ack_at = 17;
        do_req(1'b0, 1'b0, 64'h308, 64'd0, lat, e, rd, nreq);
        chk("t5_late_err",  64'(e), 64'd1);
        chk("t5_late_nreq", 64'(nreq), 64'd16);
        ack_at = 16; mem_data = 64'hA5A5_5A5A_0F0F_F0F0;
        do_req(1'b0, 1'b0, 64'h310, 64'd0, lat, e, rd, nreq);
        chk("t5_edge_err",   64'(e), 64'd0);
        chk("t5_edge_rdata", rd, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("t5_edge_nreq",  64'(nreq), 64'd16);

        // Reset in the 3rd WAIT cycle, then a stray ack
        ack_at = 0; k = 0;
        bus.f_req = 1'b1; bus.f_addr = 64'h80;
        for (int i = 0; i < 10 && k < 3; i++) begin
            @(negedge clk);
            if (bus.mem_req) k++;
        end
        chk("t6_wait3", 64'(k), 64'd3);
        reset = 1'b1;
        f0 = f_done_cnt; d0 = d_done_cnt;
        @(posedge clk); #1;
        reset = 1'b0; bus.f_req = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        chk("t6_mem_req", 64'(bus.mem_req), 64'd0);
        chk("t6_busy",    64'(bus.busy),    64'd0);
        chk("t6_f_rdata", bus.f_rdata,      64'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(f_done_cnt - f0 + d_done_cnt - d0), 64'd0);
        ack_at = 1; mem_data = 64'h5555_AAAA_5555_AAAA;
        do_req(1'b1, 1'b0, 64'h20, 64'd0, lat, e, rd, nreq);
        chk("t6_next_err",   64'(e), 64'd0);
        chk("t6_next_rdata", rd, 64'h5555_AAAA_5555_AAAA);
        chk("t6_next_lat",   64'(lat), 64'd3);
        chk("t6_next_nreq",  64'(nreq), 64'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction fetch port (F) and data memory stage port (D).
- Arbitrates requests, with D having priority and bounded starvation of F.
- Runs one transaction at a time through a req/ack handshake to the memory.
- Reports completion and error to each requester. The pipeline stalls the owning stage until that requester's done pulse.

Parameters:
- MEM_BYTES, 8192: memory size in bytes; an address >= MEM_BYTES is out of range.
- MAX_STREAK, 4: maximum consecutive D grants while F is waiting before F is forced.
- TIMEOUT, 16: maximum mem_req cycles allowed without mem_ack before the transaction aborts.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch read request; held until f_done.
- f_addr  input  64  fetch byte address; stable while f_req is high.
- f_rdata  output  64  fetch read data; valid with f_done.
- f_done  output  1  one-cycle completion pulse for fetch.
- f_err  output  1  fetch error; valid with f_done.
- d_req  input  1  data request; held until d_done.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  64  data byte address.
- d_wdata  input  64  write data.
- d_rdata  output  64  data read data; valid with d_done.
- d_done  output  1  one-cycle completion pulse for data.
- d_err  output  1  data error; valid with d_done.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  64  memory address.
- mem_wdata  output  64  memory write data.
- mem_rdata  input  64  memory read data; valid with mem_ack.
- mem_ack  input  1  memory completion, one cycle.
- owner_d  output  1  1 while the current transaction belongs to D.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (synchronous):
  - State IDLE; streak counter 0; timeout counter 0.
  - All outputs 0, including rdata and latched address/data.
- Arbitration in IDLE, on each clock:
  - If d_req and (!f_req or streak < MAX_STREAK), grant D.
  - Else if f_req, grant F.
  - Else stay in IDLE.
- Streak counter update at grant:
  - D grant with f_req high: streak increments, saturating at MAX_STREAK.
  - D grant with f_req low: streak resets to 0.
  - Any F grant: streak resets to 0.
- At grant, the arbiter latches owner, address, we and wdata. An F grant always latches we = 0.
- Error check at grant:
  - Out of range for F: f_addr >= MEM_BYTES.
  - Out of range for D: d_addr+8 > MEM_BYTES (64-bit compare, no overflow wrap); also treat d_addr >= MEM_BYTES as an error.
  - Misaligned for D: d_addr[2:0] != 0. F has no alignment rule.
  - On error: go directly to DONE with err = 1 and rdata = 0. No mem_req is issued.
- WAIT:
  - mem_req = 1; mem_addr, mem_we and mem_wdata come from the latched values.
  - Timeout counter increments every WAIT cycle.
  - On mem_ack: capture mem_rdata for reads (0 for writes) and go to DONE with err = 0.
  - If the TIMEOUT-th WAIT cycle has no ack: go to DONE with err = 1 and rdata = 0.
  - If ack arrives on the TIMEOUT-th cycle, the ack wins.
- DONE (exactly one cycle):
  - The owner's done pulse is 1, with rdata and err valid. The other port's done/err are 0.
  - mem_req = 0. Requests are not sampled.
  - Next state is IDLE, timeout counter cleared.
  - A requester must drop req, or present a new request, in the cycle after done.
- Latency:
  - Grant at edge N: mem_req is visible in cycle N+1.
  - Ack in cycle N+k: done is visible in cycle N+k+1.
  - Minimum 3 cycles from request sample to done. An error takes 2 cycles.
- Other rules:
  - mem_ack outside WAIT is ignored.
  - owner_d holds its last value in IDLE.
  - Reset mid-transaction: mem_req drops after the reset edge, no done is issued, and a late mem_ack is ignored.
  - f_rdata and d_rdata hold their last values between transactions.

Test Plan:
- F only, f_addr=0x10, memory acks on the 2nd mem_req cycle with 0x1122334455667788 -> mem_we=0, mem_addr=0x10; f_done high one cycle, f_rdata=0x1122334455667788, f_err=0; d_done stays 0.
- f_req and d_req raised together and held (each re-requesting after done), MAX_STREAK=4, 1-cycle ack -> grant order D,D,D,D,F,D,D,D,D,F.
- D write d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF for the whole WAIT; d_done with d_rdata=0, d_err=0.
- D read d_addr=0x43, then d_addr=MEM_BYTES -> each gives d_done, d_err=1, two cycles after the request, with mem_req never asserted.
- F read, mem_ack never given, TIMEOUT=16 -> mem_req high exactly 16 cycles, then f_done with f_err=1 and f_rdata=0. Repeat with ack on the 16th cycle -> f_err=0.
- Reset in the 3rd WAIT cycle, then mem_ack one cycle later -> mem_req=0, busy=0, no done pulse, streak=0; the next request completes normally.
